// File: rtl/mac_stream_accumulator.sv
// mac_stream_accumulator
// Sequences a valid/ready stream of signed operand pairs through an external
// combinational MAC (C = A*B + D), keeps a saturating running sum per packet
// and presents one dot-product result per packet on a valid/ready output.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holds valid and payload stable until
// the transfer; out_valid/out_* never change while out_valid=1 and
// out_ready=0. in_ready depends only on registered state, never on in_valid.

module mac_stream_accumulator #(
  parameter int N     = 32,
  parameter int M     = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_a,
  input  logic [M-1:0]         in_b,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic [N-1:0]         mac_a,
  output logic [M-1:0]         mac_b,
  output logic [N+M-1:0]       mac_d,
  input  logic [N+M:0]         mac_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N+M-1:0]       out_data,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf,
  output logic [1:0]           dbg_state
);

  localparam int W = N + M;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic               start_new;
  logic               overflow;
  logic [W-1:0]       sat;
  logic [CNT_W-1:0]   count_upd;
  logic               ovf_upd;

  // Saturate the (W+1)-bit MAC sum to W bits and decide packet-start context
  always_comb begin
    overflow  = mac_c[W] != mac_c[W-1];
    sat       = mac_c[W-1:0];
    if (overflow) begin
      // Sign bit of the wide sum tells which rail was crossed
      sat = mac_c[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    accept    = in_valid & in_ready;
    // A pair arriving in IDLE always opens a packet; in_first reopens one
    start_new = (state_q == S_IDLE) | in_first;
    if (start_new) begin
      count_upd = CNT_W'(1);
      ovf_upd   = overflow;
    end else begin
      // Term counter sticks at all-ones rather than wrapping
      count_upd = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
      ovf_upd   = ovf_q | overflow;
    end
  end

  // MAC operand routing: addend is zero whenever a packet is (re)starting
  always_comb begin
    mac_a = in_a;
    mac_b = in_b;
    mac_d = start_new ? '0 : acc_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = in_last ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        if (accept && in_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    in_ready  = (state_q != S_DONE);
    dbg_state = state_q;
  end

  // Datapath next values: running sum, counter, sticky flag, result holding
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          acc_d   = sat;
          count_d = count_upd;
          ovf_d   = ovf_upd;
          if (in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = sat;
            out_count_d = count_upd;
            out_ovf_d   = ovf_upd;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
        end
      end
      default: begin
        acc_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Registered result port
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_count = out_count_q;
    out_ovf   = out_ovf_q;
  end

endmodule

// File: tb/tb_mac_stream_accumulator.sv
// Bench for mac_stream_accumulator at N=M=8, CNT_W=4 with a behavioural MAC
// hooked to the mac_* ports. Expected results come from an integer model of
// the saturating dot product and are queued when the last beat is accepted.

module tb_mac_stream_accumulator;

  localparam int N = 8;
  localparam int M = 8;
  localparam int CNT_W = 4;
  localparam int W = N + M;
  localparam int EW = W + CNT_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0;
  logic [M-1:0]     in_b = '0;
  logic             in_first = 1'b0;
  logic             in_last = 1'b0;
  logic [N-1:0]     mac_a;
  logic [M-1:0]     mac_b;
  logic [W-1:0]     mac_d;
  logic [W:0]       mac_c;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic [1:0]       dbg_state;

  // Behavioural MAC: C = A*B + D, signed, W+1 bits
  int mac_sum;
  assign mac_sum = int'($signed(mac_a)) * int'($signed(mac_b)) + int'($signed(mac_d));
  assign mac_c   = mac_sum[W:0];

  mac_stream_accumulator #(.N(N), .M(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_d(mac_d), .mac_c(mac_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model state
  int  m_acc    = 0;
  int  m_cnt    = 0;
  bit  m_ovf    = 0;
  bit  m_active = 0;

  task automatic model_beat(input logic [N-1:0] a, input logic [M-1:0] b,
                            input logic first, input logic last);
    int  s;
    bit  o;
    bit  restart;
    restart = !m_active || first;
    s = int'($signed(a)) * int'($signed(b)) + (restart ? 0 : m_acc);
    o = 0;
    if (s > 32767)  begin s = 32767;  o = 1; end
    if (s < -32768) begin s = -32768; o = 1; end
    m_acc = s;
    if (restart) begin
      m_cnt = 1;
      m_ovf = o;
    end else begin
      m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
      m_ovf = m_ovf | o;
    end
    m_active = 1;
    if (last) begin
      logic [W-1:0] d;
      logic [CNT_W-1:0] c;
      d = s[W-1:0];
      c = m_cnt[CNT_W-1:0];
      exp_q.push_back({d, c, m_ovf});
      m_active = 0;
      m_acc    = 0;
    end
  endtask

  // Result monitor: a transfer is seen at the negedge before its rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'(out_valid), 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_data",  32'(out_data),  32'(e[EW-1 -: W]));
        check("out_count", 32'(out_count), 32'(e[CNT_W:1]));
        check("out_ovf",   32'(out_ovf),   32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [N-1:0] a, input logic [M-1:0] b,
                           input logic first, input logic last);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_first = first; in_last = last;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      model_beat(a, b, first, last);
    end
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  bit rand_rdy = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Three-term packet: 12 - 10 - 7 = -5, result one cycle after last beat
    send_beat(8'sd3, 8'sd4, 1'b1, 1'b0);
    send_beat(-8'sd2, 8'sd5, 1'b0, 1'b0);
    check("no_early_valid", 32'(out_valid), 32'd0);
    send_beat(8'sd7, -8'sd1, 1'b0, 1'b1);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h0000_FFFB);
    drain("t1_drain");
    idle_cycles(1);

    // Single-beat extreme product
    send_beat(-8'sd128, 8'sd127, 1'b1, 1'b1);
    drain("t2_drain");
    idle_cycles(1);

    // Positive saturation, then accumulation continues from the rail
    send_beat(-8'sd128, -8'sd128, 1'b1, 1'b0);
    send_beat(-8'sd128, -8'sd128, 1'b0, 1'b0);
    send_beat(-8'sd128, -8'sd128, 1'b0, 1'b1);
    drain("t3_drain");
    idle_cycles(1);

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send_beat(8'sd1, 8'sd2, 1'b1, 1'b0);
    send_beat(8'sd3, 8'sd4, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data",  32'(out_data),  32'd14);
      check("hold_count", 32'(out_count), 32'd2);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    idle_cycles(1);

    // Mid-packet restart via in_first: only (2,3),(4,4) count
    send_beat(8'sd10, 8'sd10, 1'b1, 1'b0);
    send_beat(8'sd1, 8'sd1, 1'b0, 1'b0);
    send_beat(8'sd2, 8'sd3, 1'b1, 1'b0);
    send_beat(8'sd4, 8'sd4, 1'b0, 1'b1);
    drain("t5_drain");
    idle_cycles(1);

    // Reset in the middle of a packet discards it
    send_beat(8'sd20, 8'sd20, 1'b1, 1'b0);
    send_beat(8'sd30, 8'sd3, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    m_active = 0;
    m_acc = 0;
    #1;
    check("mid_rst_state",     32'(dbg_state), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_out_count", 32'(out_count), 32'd0);
    check("mid_rst_out_ovf",   32'(out_ovf),   32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
    send_beat(8'sd5, 8'sd5, 1'b1, 1'b1);
    drain("t6_drain");
    idle_cycles(1);

    // Random packets with random downstream backpressure
    rand_rdy = 1;
    for (int p = 0; p < 25; p++) begin
      int len;
      len = $urandom_range(1, 18);
      for (int k = 0; k < len; k++) begin
        send_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'(k == 0), 1'(k == len - 1));
        if ($urandom_range(0, 3) == 0) idle_cycles(1);
      end
    end
    @(negedge clk);
    rand_rdy  = 0;
    out_ready = 1'b1;
    drain("rand_drain");
    idle_cycles(2);
    check("final_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
